// File: rtl/instruction_fetch_queue_if.sv
// rtl/instruction_fetch_queue_if.sv - memory request/response and decoder handshake bundle for the fetch queue
interface instruction_fetch_queue_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  halt;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;
  logic [CW-1:0]         queue_count;

  modport master (
    output mem_addr, mem_rd_en, instr_valid, instr, instr_pc, queue_count,
    input  mem_rd_data, redirect, redirect_addr, halt, instr_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, instr_valid, instr, instr_pc, queue_count,
    output mem_rd_data, redirect, redirect_addr, halt, instr_ready
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - sequential instruction prefetch with credit-limited FIFO and redirect flush
module instruction_fetch_queue #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  instruction_fetch_queue_if.master   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] pending_pc_q, pending_pc_d;
  logic                  pending_q, pending_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];

  logic          issue, push, pop, head_valid;
  logic [CW:0]   credit_used;

  // An in-flight request holds a slot, so a response can never find the FIFO full.
  always_comb begin
    credit_used  = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
    issue        = reset & ~bus.halt & ~bus.redirect & (credit_used < (CW+1)'(DEPTH));
    head_valid   = (count_q != '0);
    push         = pending_q & ~bus.redirect;
    pop          = head_valid & bus.instr_ready;

    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    pending_d    = pending_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_addr;
      pending_d  = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      pending_d = issue;
      if (issue) begin
        pending_pc_d = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + ADDR_WIDTH'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
      pending_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      pending_q    <= pending_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Entry storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= bus.mem_rd_data;
      pc_q[wr_ptr_q]   <= pending_pc_q;
    end
  end

  assign bus.mem_rd_en   = issue;
  assign bus.mem_addr    = fetch_pc_q;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_valid ? data_q[rd_ptr_q] : '0;
  assign bus.instr_pc    = head_valid ? pc_q[rd_ptr_q]   : '0;
  assign bus.queue_count = count_q;
endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
- Fetch stage that sits directly upstream of the instruction decoder.
- Generates sequential fetch addresses to the synchronous instruction memory and captures the returned bytes into a small prefetch FIFO.
- Presents instructions to the decoder with a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes queued and in-flight fetches and restarts fetch at a new address.

Parameters:
ADDR_WIDTH, 8, width of fetch address / PC
DATA_WIDTH, 8, instruction width
DEPTH, 4, FIFO entries (power of two, >= 2)
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
mem_addr  output  ADDR_WIDTH  fetch address to instruction memory
mem_rd_en  output  1  fetch request this cycle
mem_rd_data  input  DATA_WIDTH  memory read data, valid the cycle after the request edge
redirect  input  1  flush and restart fetch at redirect_addr
redirect_addr  input  ADDR_WIDTH  new fetch address
halt  input  1  suppress new fetch requests; queue still drains
instr_valid  output  1  head entry valid
instr  output  DATA_WIDTH  head instruction
instr_pc  output  ADDR_WIDTH  address of head instruction
instr_ready  input  1  decoder accepts head this cycle
queue_count  output  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (reset low, asynchronous):
  - fetch_pc = RESET_PC; queue empty; pending = 0.
  - Outputs: instr_valid = 0, instr = 0, instr_pc = 0, queue_count = 0.
  - mem_rd_en is forced 0 combinationally while reset is low. mem_addr = RESET_PC.
- Issue (combinational): mem_rd_en = reset & !halt & !redirect & (count + pending < DEPTH). mem_addr = fetch_pc.
- On an issuing edge:
  - pending <= 1.
  - pending_pc <= fetch_pc.
  - fetch_pc <= fetch_pc + 1, modulo 2^ADDR_WIDTH (0xFF wraps to 0x00).
- Response: on the edge after an issue (pending = 1), push {mem_rd_data, pending_pc} into the FIFO. pending clears unless a new issue occurs on the same edge.
- Throughput: at most one request and one response per cycle. Sustained 1 instruction/cycle when the decoder holds instr_ready high.
- Pop: occurs when instr_valid & instr_ready. Push and pop on the same edge leave count unchanged.
- Empty queue: instr and instr_pc read 0.
- Full handling: the credit rule (count + pending < DEPTH) guarantees a response always has space. Push to a full FIFO cannot occur; the verification bench asserts this.
- Latency: first request at the first rising edge with reset high. instr_valid rises after the next edge, i.e. 2 cycles from reset release to the first instruction.
- Redirect (has priority over everything):
  - On that edge: FIFO cleared (count = 0); pending cleared, so the response in flight is discarded; fetch_pc <= redirect_addr.
  - No request is issued during the redirect cycle. Fetch from redirect_addr starts the following cycle.
  - A pop coincident with redirect counts as accepted by the decoder; the queue is still cleared.
  - A redirect during halt updates fetch_pc; no requests are issued until halt drops.
- Halt: blocks new requests only. A pending response still pushes, and pops continue normally.
- Reset mid-operation: all state returns to reset values immediately, including discarding any pending response.

Test Plan:
- Reset release, memory holds 0x10+addr, instr_ready = 1 -> instr_valid rises 2 cycles after release. Decoder sees (instr, instr_pc) = (0x10,0x00), (0x11,0x01), ... on consecutive cycles.
- instr_ready = 0 from reset -> exactly DEPTH = 4 requests (addr 0..3), queue_count reaches 4, mem_rd_en stays 0. Raise ready -> entries 0..3 drain in order, then fetch resumes at 0x04.
- Redirect to 0x40 while queue holds 3 entries and a request is pending -> next cycle queue_count = 0 and the stale response is dropped. First instruction out has instr_pc = 0x40; no entry with a pre-redirect PC ever appears.
- RESET_PC = 0xFE, free-running -> instr_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- halt pulsed for 3 cycles with a request pending -> the pending response is still enqueued, no new mem_rd_en during halt, and fetch resumes at the next sequential address without gaps or duplicates.
- reset asserted asynchronously mid-stream, between clock edges -> outputs go to reset values without waiting for a clock edge. After release, fetch restarts at RESET_PC.
